// File: rtl/icache_control_nway.sv
// N-way set-associative I-cache controller: LOOKUP/FETCH FSM, invalid-way-first victim, deferred flush.
// Optional hit/miss perf counters are built only when ICACHE_PERF_CNT_EN is defined.
//
// state  | meaning
// LOOKUP | idle / tag compare; serves hits and flushes, launches misses
// FETCH  | line fill from pmem into way victim_q
module icache_control_nway #(
    parameter int WAYS     = 2,
    parameter int WAY_BITS = $clog2(WAYS),
    parameter int CNT_W    = 32
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                mem_read_i,
    input  logic                flush_i,
    input  logic [WAYS-1:0]     hit_way_i,
    input  logic [WAYS-1:0]     valid_way_i,
    input  logic [WAY_BITS-1:0] plru_victim_i,
    input  logic                pmem_resp_i,
    output logic                mem_resp_o,
    output logic                pmem_read_o,
    output logic                data_sel_o,
    output logic [WAYS-1:0]     data_we_o,
    output logic [WAYS-1:0]     load_tag_o,
    output logic [WAYS-1:0]     load_valid_o,
    output logic [WAYS-1:0]     set_valid_o,
    output logic                clear_valid_all_o,
    output logic                lru_load_o,
    output logic [WAY_BITS-1:0] lru_way_o,
    output logic [CNT_W-1:0]    hit_count_o,
    output logic [CNT_W-1:0]    miss_count_o
);

    typedef enum logic {LOOKUP = 1'b0, FETCH = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [WAY_BITS-1:0] victim_q, victim_d;
    logic                flush_pend_q, flush_pend_d;
    logic [WAY_BITS-1:0] hit_idx, inv_idx;
    logic [WAYS-1:0]     victim_oh;
    logic                any_hit, any_inv, do_flush;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit_idx = '0;
        inv_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_way_i[i])    hit_idx = WAY_BITS'(i);
            if (!valid_way_i[i]) inv_idx = WAY_BITS'(i);
        end
    end

    always_comb begin
        victim_oh           = '0;
        victim_oh[victim_q] = 1'b1;
    end

    assign any_hit  = |hit_way_i;
    assign any_inv  = ~&valid_way_i;
    assign do_flush = flush_i | flush_pend_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= LOOKUP;
            victim_q     <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        flush_pend_d = flush_pend_q;
        case (state_q)
            LOOKUP: begin
                if (do_flush) begin
                    flush_pend_d = 1'b0;
                end else if (mem_read_i && !any_hit) begin
                    victim_d = any_inv ? inv_idx : plru_victim_i;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                // A flush mid-fill is remembered and executed once back in LOOKUP.
                if (flush_i)     flush_pend_d = 1'b1;
                if (pmem_resp_i) state_d      = LOOKUP;
            end
            default: state_d = LOOKUP;
        endcase
    end

    always_comb begin
        mem_resp_o        = 1'b0;
        pmem_read_o       = 1'b0;
        data_sel_o        = 1'b0;
        data_we_o         = '0;
        load_tag_o        = '0;
        load_valid_o      = '0;
        set_valid_o       = '0;
        clear_valid_all_o = 1'b0;
        lru_load_o        = 1'b0;
        lru_way_o         = '0;
        case (state_q)
            LOOKUP: begin
                if (do_flush) begin
                    clear_valid_all_o = 1'b1;
                end else if (mem_read_i && any_hit) begin
                    mem_resp_o = 1'b1;
                    lru_load_o = 1'b1;
                    lru_way_o  = hit_idx;
                end
            end
            FETCH: begin
                pmem_read_o = 1'b1;
                data_sel_o  = 1'b1;
                data_we_o   = victim_oh;
                if (pmem_resp_i) begin
                    load_tag_o   = victim_oh;
                    load_valid_o = victim_oh;
                    set_valid_o  = victim_oh;
                    lru_load_o   = 1'b1;
                    lru_way_o    = victim_q;
                    mem_resp_o   = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic             hit_evt, miss_evt;

    assign hit_evt  = (state_q == LOOKUP) && !do_flush && mem_read_i && any_hit;
    assign miss_evt = (state_q == LOOKUP) && (state_d == FETCH);

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_evt && !(&hit_cnt_q))   hit_cnt_d  = hit_cnt_q + 1'b1;
        if (miss_evt && !(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`else
    assign hit_count_o  = '0;
    assign miss_count_o = '0;
`endif

`ifndef SYNTHESIS
    a_multi_hit: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (state_q == LOOKUP && mem_read_i) |-> $onehot0(hit_way_i))
        else $error("icache_control_nway: more than one way hit");
`endif

endmodule

// File: tb/tb_icache_control_nway.sv
// Randomized scoreboard bench for icache_control_nway (WAYS=4, CNT_W=3).
// Stimulus pushes expected responses; a negedge monitor pops and compares them.
module tb_icache_control_nway;

    localparam int WAYS  = 4;
    localparam int WB    = 2;
    localparam int CNT_W = 3;
    localparam int K_FLUSH = 0, K_FILL = 1, K_HIT = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mem_read, flush, pmem_resp;
    logic [WAYS-1:0]  hit_way, valid_way;
    logic [WB-1:0]    plru_victim;
    logic             mem_resp, pmem_read, data_sel, clear_valid_all, lru_load;
    logic [WAYS-1:0]  data_we, load_tag, load_valid, set_valid;
    logic [WB-1:0]    lru_way;
    logic [CNT_W-1:0] hit_count, miss_count;

    icache_control_nway #(.WAYS(WAYS), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .mem_read_i(mem_read), .flush_i(flush),
        .hit_way_i(hit_way), .valid_way_i(valid_way), .plru_victim_i(plru_victim),
        .pmem_resp_i(pmem_resp), .mem_resp_o(mem_resp), .pmem_read_o(pmem_read),
        .data_sel_o(data_sel), .data_we_o(data_we), .load_tag_o(load_tag),
        .load_valid_o(load_valid), .set_valid_o(set_valid),
        .clear_valid_all_o(clear_valid_all), .lru_load_o(lru_load), .lru_way_o(lru_way),
        .hit_count_o(hit_count), .miss_count_o(miss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int kind; int cyc; int way; } rec_t;
    rec_t q[$];

    int vectors = 0, errors = 0;
    int n_hit = 0, n_miss = 0;
    bit pend = 0;
    logic            exp_fetch = 1'b0;
    logic [WAYS-1:0] exp_we = '0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(int n);
        int mx = (1 << CNT_W) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk_cnt();
`ifdef ICACHE_PERF_CNT_EN
        chk("hit_count", hit_count, sat(n_hit));
        chk("miss_count", miss_count, sat(n_miss));
`else
        chk("hit_count", hit_count, 0);
        chk("miss_count", miss_count, 0);
`endif
    endtask

    // Monitor: per-cycle fetch expectations plus queued responses.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("pmem_read", pmem_read, exp_fetch);
            if (exp_fetch) begin
                chk("fetch_we", data_we, exp_we);
                chk("fetch_sel", data_sel, 1);
            end
            while (q.size() > 0 && q[0].cyc < cyc) begin
                vectors++;
                errors++;
                $display("FAIL missing_resp cyc=%0d actual=none expected kind %0d at cyc %0d",
                         cyc, q[0].kind, q[0].cyc);
                void'(q.pop_front());
            end
            if (mem_resp || clear_valid_all) begin
                if (q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_resp cyc=%0d actual mem_resp=%0b clear=%0b expected none",
                             cyc, mem_resp, clear_valid_all);
                end else begin
                    rec_t r;
                    int obs;
                    r = q.pop_front();
                    obs = clear_valid_all ? K_FLUSH : (pmem_read ? K_FILL : K_HIT);
                    chk("resp_kind", obs, r.kind);
                    chk("resp_cycle", cyc, r.cyc);
                    case (r.kind)
                        K_FLUSH: chk("flush_quiet", {mem_resp, lru_load, data_we}, 0);
                        K_FILL: begin
                            chk("fill_tag", load_tag, 1 << r.way);
                            chk("fill_valid", {load_valid, set_valid}, {4'(1 << r.way), 4'(1 << r.way)});
                            chk("fill_lru", {lru_load, lru_way}, {1'b1, 2'(r.way)});
                        end
                        default: begin
                            chk("hit_lru", {lru_load, lru_way}, {1'b1, 2'(r.way)});
                            chk("hit_nowrite", {data_we, load_tag, load_valid, set_valid}, 0);
                        end
                    endcase
                end
            end else if (!exp_fetch) begin
                chk("idle_outputs", {mem_resp, pmem_read, data_sel, data_we, load_tag, load_valid,
                                     set_valid, clear_valid_all, lru_load, lru_way}, 0);
            end
        end
    end

    task automatic idle_inputs();
        mem_read = 0; flush = 0; pmem_resp = 0; hit_way = '0; valid_way = '0; plru_victim = '0;
        exp_fetch = 0; exp_we = '0;
    endtask

    task automatic do_hit(int w, bit with_flush);
        mem_read  = 1;
        hit_way   = 4'(1 << w);
        valid_way = 4'($urandom);
        flush     = with_flush;
        if (with_flush) begin
            q.push_back('{K_FLUSH, cyc, 0});
            tick();
            flush = 0;
        end
        q.push_back('{K_HIT, cyc, w});
        n_hit++;
        tick();
        mem_read = 0;
        hit_way  = '0;
    endtask

    task automatic do_miss(logic [WAYS-1:0] vw, logic [WB-1:0] plru, int nf, int fl_at, bit do_rst);
        int victim;
        victim = plru;
        for (int i = 0; i < WAYS; i++) begin
            if (!vw[i]) begin
                victim = i;
                break;
            end
        end
        mem_read = 1; hit_way = '0; valid_way = vw; plru_victim = plru; flush = 0;
        exp_fetch = 0;
        n_miss++;
        tick();
        for (int k = 1; k <= nf; k++) begin
            mem_read    = 1'($urandom_range(0, 1));
            hit_way     = 4'($urandom);
            valid_way   = 4'($urandom);
            plru_victim = 2'($urandom);
            exp_fetch   = 1;
            exp_we      = 4'(1 << victim);
            flush       = (k == fl_at);
            if (k == fl_at) pend = 1;
            if (do_rst && k == 2) begin
                rst_n     = 0;
                pmem_resp = 0;
                tick();
                rst_n = 1;
                idle_inputs();
                n_hit = 0; n_miss = 0; pend = 0;
                tick();
                chk_cnt();
                return;
            end
            pmem_resp = (k == nf);
            if (k == nf) q.push_back('{K_FILL, cyc, victim});
            tick();
        end
        idle_inputs();
        if (pend) begin
            pend = 0;
            if ($urandom_range(0, 1) == 1) begin
                int w = $urandom_range(0, WAYS - 1);
                mem_read = 1;
                hit_way  = 4'(1 << w);
                q.push_back('{K_FLUSH, cyc, 0});
                tick();
                q.push_back('{K_HIT, cyc, w});
                n_hit++;
                tick();
                idle_inputs();
            end else begin
                q.push_back('{K_FLUSH, cyc, 0});
                tick();
            end
        end
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1;
        chk_cnt();
        tick();

        do_hit(2, 0);
        chk_cnt();
        do_miss(4'b1011, 2'd0, 6, 0, 0);
        chk_cnt();
        do_miss(4'b1111, 2'd3, 4, 0, 0);
        chk_cnt();
        do_miss(4'b0000, 2'd1, 1, 1, 0);
        do_miss(4'b1111, 2'd2, 3, 3, 0);
        do_hit(1, 1);
        chk_cnt();
        do_miss(4'b0111, 2'd0, 4, 0, 1);

        for (int t = 0; t < 200; t++) begin
            int sel = $urandom_range(0, 9);
            if (sel <= 3) begin
                do_hit($urandom_range(0, WAYS - 1), ($urandom_range(0, 4) == 0));
            end else if (sel <= 6) begin
                int nf = $urandom_range(1, 6);
                do_miss(4'($urandom), 2'($urandom), nf, $urandom_range(1, nf + 3), 0);
            end else if (sel == 7) begin
                do_miss(4'($urandom), 2'($urandom), $urandom_range(3, 6), $urandom_range(1, 4),
                        ($urandom_range(0, 2) == 0));
            end else if (sel == 8) begin
                flush = 1;
                q.push_back('{K_FLUSH, cyc, 0});
                tick();
                flush = 0;
            end else begin
                hit_way   = 4'($urandom);
                valid_way = 4'($urandom);
                tick();
                idle_inputs();
            end
            chk_cnt();
        end

        idle_inputs();
        tick();
        tick();
        chk_cnt();
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
